// File: rtl/ring_osc_freq_meter.sv
// Ring-oscillator frequency meter: enables the oscillator, waits for it to settle,
// then counts synchronized rising edges of osc_i over a programmable clk_i window.
module ring_osc_freq_meter #(
   parameter int CTRL_WIDTH    = 5,
   parameter int CNT_WIDTH     = 16,
   parameter int WIN_WIDTH     = 16,
   parameter int SETTLE_CYCLES = 64
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [CTRL_WIDTH-1:0] freq_sel_i,
   input  logic [WIN_WIDTH-1:0]  window_i,
   input  logic                  osc_i,
   output logic                  osc_enable_o,
   output logic [CTRL_WIDTH-1:0] freq_sel_o,
   output logic                  busy_o,
   output logic [CNT_WIDTH-1:0]  count_o,
   output logic                  overflow_o,
   output logic                  valid_o
);

   // state   | meaning
   // IDLE    | oscillator off, waiting for start_i
   // SETTLE  | oscillator on, edges ignored for SETTLE_CYCLES cycles
   // MEASURE | oscillator on, counting edges for the captured window
   // DONE    | one-cycle result strobe, oscillator off
   typedef enum logic [1:0] {IDLE, SETTLE, MEASURE, DONE} state_t;

   localparam int SW = $clog2(SETTLE_CYCLES) + 1;

   state_t                state;
   logic [SW-1:0]         settle_cnt;
   logic [WIN_WIDTH-1:0]  win_cnt;
   logic [CNT_WIDTH-1:0]  edge_cnt;
   logic                  sat;
   logic                  sync_1;
   logic                  sync_2;
   logic                  hist;
   logic                  edge_det;
   logic [CNT_WIDTH-1:0]  cnt_nxt;
   logic                  sat_nxt;

   assign edge_det = sync_2 & ~hist;

   always_comb begin
      cnt_nxt = edge_cnt;
      sat_nxt = sat;
      if (edge_det) begin
         if (edge_cnt == {CNT_WIDTH{1'b1}}) begin
            sat_nxt = 1'b1;
         end else begin
            cnt_nxt = edge_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state        <= IDLE;
         settle_cnt   <= '0;
         win_cnt      <= '0;
         edge_cnt     <= '0;
         sat          <= 1'b0;
         sync_1       <= 1'b0;
         sync_2       <= 1'b0;
         hist         <= 1'b0;
         osc_enable_o <= 1'b0;
         freq_sel_o   <= '0;
         busy_o       <= 1'b0;
         count_o      <= '0;
         overflow_o   <= 1'b0;
         valid_o      <= 1'b0;
      end else begin
         // edge pipeline runs in every state so history is valid when MEASURE opens
         sync_1 <= osc_i;
         sync_2 <= sync_1;
         hist   <= sync_2;
         case (state)
            IDLE: begin
               if (start_i) begin
                  freq_sel_o   <= freq_sel_i;
                  win_cnt      <= (window_i == '0) ? '0 : window_i - 1'b1;
                  settle_cnt   <= SW'(SETTLE_CYCLES - 1);
                  edge_cnt     <= '0;
                  sat          <= 1'b0;
                  osc_enable_o <= 1'b1;
                  busy_o       <= 1'b1;
                  state        <= SETTLE;
               end
            end
            SETTLE: begin
               if (settle_cnt == '0) begin
                  state <= MEASURE;
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            MEASURE: begin
               edge_cnt <= cnt_nxt;
               sat      <= sat_nxt;
               if (win_cnt == '0) begin
                  count_o      <= cnt_nxt;
                  overflow_o   <= sat_nxt;
                  valid_o      <= 1'b1;
                  osc_enable_o <= 1'b0;
                  state        <= DONE;
               end else begin
                  win_cnt <= win_cnt - 1'b1;
               end
            end
            DONE: begin
               valid_o <= 1'b0;
               busy_o  <= 1'b0;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ring_osc_freq_meter.sv
// Bench for ring_osc_freq_meter: a default-size instance and a 4-bit-counter
// instance, with a result scoreboard per instance checked on every valid_o.
`timescale 1ns/1ps
module tb_ring_osc_freq_meter;

   localparam int S_M = 64;
   localparam int S_S = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic        start_m = 1'b0, start_s = 1'b0;
   logic [4:0]  fsel_m = '0, fsel_s = '0;
   logic [15:0] win_m = '0, win_s = '0;
   logic        osc_m, osc_s;
   logic        en_m, en_s, busy_m, busy_s, ovf_m, ovf_s, valid_m, valid_s;
   logic [4:0]  fselo_m, fselo_s;
   logic [15:0] cnt_m;
   logic [3:0]  cnt_s;

   ring_osc_freq_meter #(.CTRL_WIDTH(5), .CNT_WIDTH(16), .WIN_WIDTH(16), .SETTLE_CYCLES(S_M)) dut_m (
      .clk_i(clk), .rst_i(rst), .start_i(start_m), .freq_sel_i(fsel_m), .window_i(win_m),
      .osc_i(osc_m), .osc_enable_o(en_m), .freq_sel_o(fselo_m), .busy_o(busy_m),
      .count_o(cnt_m), .overflow_o(ovf_m), .valid_o(valid_m));

   ring_osc_freq_meter #(.CTRL_WIDTH(5), .CNT_WIDTH(4), .WIN_WIDTH(16), .SETTLE_CYCLES(S_S)) dut_s (
      .clk_i(clk), .rst_i(rst), .start_i(start_s), .freq_sel_i(fsel_s), .window_i(win_s),
      .osc_i(osc_s), .osc_enable_o(en_s), .freq_sel_o(fselo_s), .busy_o(busy_s),
      .count_o(cnt_s), .overflow_o(ovf_s), .valid_o(valid_s));

   // oscillator models: half period in ns (0 = tied to tie value), offset from clk edges
   int half_m = 0, half_s = 0;
   bit tie_m = 1'b0, tie_s = 1'b0;
   initial begin
      osc_m = 1'b0;
      #0.3;
      forever begin
         if (half_m == 0) begin osc_m = tie_m; #1; end
         else begin #(half_m) osc_m = ~osc_m; end
      end
   end
   initial begin
      osc_s = 1'b0;
      #0.7;
      forever begin
         if (half_s == 0) begin osc_s = tie_s; #1; end
         else begin #(half_s) osc_s = ~osc_s; end
      end
   end

   typedef struct {int cnt; int tol; bit ovf; int cyc; int fsel;} exp_t;
   exp_t sb_m[$];
   exp_t sb_s[$];

   int n_chk = 0, n_fail = 0;
   int vcnt_m = 0, vcnt_s = 0;
   bit pv_m = 1'b0, pv_s = 1'b0;

   task automatic chk(input string name, input bit ok, input int act, input int req);
      n_chk++;
      if (!ok) begin
         n_fail++;
         $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
      end
   endtask

   task automatic score(input string tag, input exp_t e, input int c, input bit o, input int f);
      chk({tag, " count"}, (c >= e.cnt - e.tol) && (c <= e.cnt + e.tol), c, e.cnt);
      chk({tag, " overflow"}, o == e.ovf, int'(o), int'(e.ovf));
      chk({tag, " valid cycle"}, cyc == e.cyc, cyc, e.cyc);
      chk({tag, " freq_sel at done"}, f == e.fsel, f, e.fsel);
   endtask

   always @(negedge clk) begin
      if (valid_m) begin
         vcnt_m++;
         chk("main valid width", !pv_m, int'(pv_m), 0);
         if (sb_m.size() == 0) chk("main unexpected valid", 1'b0, 1, 0);
         else score("main", sb_m.pop_front(), int'(cnt_m), ovf_m, int'(fselo_m));
      end
      pv_m <= valid_m;
   end

   always @(negedge clk) begin
      if (valid_s) begin
         vcnt_s++;
         chk("sat valid width", !pv_s, int'(pv_s), 0);
         if (sb_s.size() == 0) chk("sat unexpected valid", 1'b0, 1, 0);
         else score("sat", sb_s.pop_front(), int'(cnt_s), ovf_s, int'(fselo_s));
      end
      pv_s <= valid_s;
   end

   task automatic start_meas(input bit sat, input int fsel, input int win,
                             input int expc, input int tol, input bit ovf);
      exp_t e;
      int   s;
      int   weff;
      s    = sat ? S_S : S_M;
      weff = (win == 0) ? 1 : win;
      @(posedge clk); #1;
      e.cnt = expc; e.tol = tol; e.ovf = ovf; e.fsel = fsel;
      e.cyc = cyc + 1 + s + weff;
      if (sat) begin
         start_s = 1'b1; fsel_s = 5'(fsel); win_s = 16'(win); sb_s.push_back(e);
      end else begin
         start_m = 1'b1; fsel_m = 5'(fsel); win_m = 16'(win); sb_m.push_back(e);
      end
      @(posedge clk); #1;
      if (sat) start_s = 1'b0; else start_m = 1'b0;
      chk("freq_sel after start", int'(sat ? fselo_s : fselo_m) == fsel,
          int'(sat ? fselo_s : fselo_m), fsel);
      chk("busy after start", (sat ? busy_s : busy_m) == 1'b1, int'(sat ? busy_s : busy_m), 1);
      chk("enable after start", (sat ? en_s : en_m) == 1'b1, int'(sat ? en_s : en_m), 1);
   endtask

   task automatic wait_idle(input bit sat, input int limit);
      int n = 0;
      while ((sat ? busy_s : busy_m) && n < limit) begin
         @(negedge clk);
         n++;
      end
      chk("idle within budget", n < limit, n, limit);
   endtask

   typedef struct {int half; bit tie; int fsel; int win; int expc; int tol;} vec_t;
   vec_t tbl[6];

   initial begin
      int v0;
      int c0;
      tbl[0] = '{50,  1'b0, 6,  1000, 100, 1};
      tbl[1] = '{100, 1'b0, 9,  400,  20,  1};
      tbl[2] = '{30,  1'b0, 31, 300,  50,  1};
      tbl[3] = '{0,   1'b1, 1,  0,    0,   0};
      tbl[4] = '{0,   1'b0, 2,  50,   0,   0};
      tbl[5] = '{15,  1'b0, 17, 90,   30,  1};

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset enable", en_m == 1'b0, int'(en_m), 0);
      chk("reset busy", busy_m == 1'b0, int'(busy_m), 0);
      chk("reset valid", valid_m == 1'b0, int'(valid_m), 0);
      chk("reset overflow", ovf_m == 1'b0, int'(ovf_m), 0);
      chk("reset count", cnt_m == 16'd0, int'(cnt_m), 0);
      chk("reset freq_sel", fselo_m == 5'd0, int'(fselo_m), 0);
      chk("reset sat count", cnt_s == 4'd0, int'(cnt_s), 0);
      @(posedge clk); #1 rst = 1'b0;

      // table-driven measurements on the default instance
      for (int i = 0; i < 6; i++) begin
         half_m = tbl[i].half;
         tie_m  = tbl[i].tie;
         repeat (20) @(posedge clk);
         v0 = vcnt_m;
         start_meas(1'b0, tbl[i].fsel, tbl[i].win, tbl[i].expc, tbl[i].tol, 1'b0);
         wait_idle(1'b0, S_M + tbl[i].win + 20);
         chk("one valid per measurement", vcnt_m - v0 == 1, vcnt_m - v0, 1);
         chk("enable off in idle", en_m == 1'b0, int'(en_m), 0);
      end

      // saturation with a 4-bit counter, then a normal follow-up
      half_s = 20;
      repeat (10) @(posedge clk);
      start_meas(1'b1, 0, 100, 15, 0, 1'b1);
      wait_idle(1'b1, S_S + 120);
      start_meas(1'b1, 4, 20, 5, 1, 1'b0);
      wait_idle(1'b1, S_S + 40);
      chk("sat valid pulses", vcnt_s == 2, vcnt_s, 2);

      // start pulses while busy are ignored
      half_m = 50;
      repeat (10) @(posedge clk);
      v0 = vcnt_m;
      start_meas(1'b0, 6, 200, 20, 1, 1'b0);
      repeat (10) @(posedge clk);
      #1 start_m = 1'b1; fsel_m = 5'd15;
      @(posedge clk); #1 start_m = 1'b0;
      chk("freq_sel kept in settle", fselo_m == 5'd6, int'(fselo_m), 6);
      repeat (120) @(posedge clk);
      #1 start_m = 1'b1; fsel_m = 5'd15;
      @(posedge clk); #1 start_m = 1'b0;
      chk("freq_sel kept in measure", fselo_m == 5'd6, int'(fselo_m), 6);
      wait_idle(1'b0, S_M + 250);
      chk("busy-start valid pulses", vcnt_m - v0 == 1, vcnt_m - v0, 1);
      chk("freq_sel held after done", fselo_m == 5'd6, int'(fselo_m), 6);

      // reset halfway through MEASURE
      start_meas(1'b0, 6, 200, 20, 1, 1'b0);
      repeat (S_M + 100) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      sb_m.delete();
      v0 = vcnt_m;
      chk("abort busy", busy_m == 1'b0, int'(busy_m), 0);
      chk("abort enable", en_m == 1'b0, int'(en_m), 0);
      chk("abort count", cnt_m == 16'd0, int'(cnt_m), 0);
      chk("abort valid", valid_m == 1'b0, int'(valid_m), 0);
      repeat (300) @(negedge clk);
      chk("no valid after abort", vcnt_m == v0, vcnt_m - v0, 0);
      start_meas(1'b0, 7, 200, 20, 1, 1'b0);
      wait_idle(1'b0, S_M + 220);
      chk("post-abort valid pulses", vcnt_m - v0 == 1, vcnt_m - v0, 1);

      // start held high: three back-to-back measurements, S+W+2 apart
      repeat (10) @(posedge clk);
      #1;
      c0 = cyc;
      v0 = vcnt_m;
      for (int i = 0; i < 3; i++) begin
         exp_t e;
         e.cnt = 3; e.tol = 1; e.ovf = 1'b0; e.fsel = 3;
         e.cyc = c0 + 1 + S_M + 30 + i * (S_M + 30 + 2);
         sb_m.push_back(e);
      end
      start_m = 1'b1; fsel_m = 5'd3; win_m = 16'd30;
      repeat (1 + 2 * (S_M + 30 + 2)) @(posedge clk);
      #1 start_m = 1'b0;
      wait_idle(1'b0, S_M + 60);
      chk("back-to-back valid pulses", vcnt_m - v0 == 3, vcnt_m - v0, 3);
      chk("scoreboard drained", sb_m.size() == 0, sb_m.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL global timeout: actual=%0d required=%0d", cyc, 0);
      $fatal(1, "timeout");
   end

endmodule
